// File: rtl/ac97_frame_rx_if.sv
// Bundles the frame input, register-response outputs and the PCM capture stream of ac97_frame_rx.
// slave is the decoder side; master is the ACLink/consumer side.
interface ac97_frame_rx_if #(
  parameter int FIFO_DEPTH = 16
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic           ac97_strobe;
  logic [255:0]   ac97_in_frame;
  logic           codec_ready;
  logic           status_valid;
  logic [6:0]     status_addr;
  logic [15:0]    status_data;
  logic [15:0]    pwr_status;
  logic [31:0]    vendor_id;
  logic           pcm_valid;
  logic           pcm_ready;
  logic [31:0]    pcm_data;
  logic [LW-1:0]  pcm_level;
  logic           overflow;
  logic [7:0]     drop_count;

  modport slave (
    input  ac97_strobe, ac97_in_frame, pcm_ready,
    output codec_ready, status_valid, status_addr, status_data, pwr_status,
           vendor_id, pcm_valid, pcm_data, pcm_level, overflow, drop_count
  );

  modport master (
    output ac97_strobe, ac97_in_frame, pcm_ready,
    input  codec_ready, status_valid, status_addr, status_data, pwr_status,
           vendor_id, pcm_valid, pcm_data, pcm_level, overflow, drop_count
  );
endinterface

// File: rtl/ac97_frame_rx.sv
// AC-link input frame decoder: codec-ready, register responses with 0x26/0x7C/0x7E cache, PCM capture FIFO.
// Optional: define AC97_RX_DROP_COUNT_EN to implement the saturating drop_count counter.
module ac97_frame_rx #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic           ac97_bitclk,
  input  logic           ac97_rst_b,
  ac97_frame_rx_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef struct packed {
    logic [4:0]  tag;
    logic [6:0]  idx;
    logic [15:0] rdata;
    logic [15:0] left;
    logic [15:0] right;
  } s0_t;

  // Slots arrive MSB first: slot bit 19 sits at the lowest frame index of the slot.
  function automatic logic [15:0] field16(input logic [255:0] f, input int base);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[15-i] = f[base+i];
    return r;
  endfunction

  s0_t  s0_d, s0_q;
  logic s0_vld;

  always_comb begin
    s0_d       = '0;
    s0_d.tag   = bus.ac97_in_frame[4:0];
    for (int i = 0; i < 7; i++) s0_d.idx[6-i] = bus.ac97_in_frame[17+i];
    s0_d.rdata = field16(bus.ac97_in_frame, 36);
    s0_d.left  = field16(bus.ac97_in_frame, 56);
    s0_d.right = field16(bus.ac97_in_frame, 76);
  end

  logic unused_frame_bits;
  assign unused_frame_bits = ^{bus.ac97_in_frame[255:92], bus.ac97_in_frame[75:72],
                               bus.ac97_in_frame[55:52], bus.ac97_in_frame[35:24],
                               bus.ac97_in_frame[16:5]};

  always_ff @(posedge ac97_bitclk) begin
    if (!ac97_rst_b) begin
      s0_q   <= '0;
      s0_vld <= 1'b0;
    end else begin
      s0_vld <= bus.ac97_strobe;
      if (bus.ac97_strobe) s0_q <= s0_d;
    end
  end

  logic        rsp_hit, push;
  logic [31:0] push_data;
  assign rsp_hit   = s0_vld & s0_q.tag[0] & s0_q.tag[1] & s0_q.tag[2];
  assign push      = s0_vld & s0_q.tag[0] & (s0_q.tag[3] | s0_q.tag[4]);
  assign push_data = {s0_q.tag[3] ? s0_q.left : 16'h0, s0_q.tag[4] ? s0_q.right : 16'h0};

  logic        codec_ready_q, status_valid_q;
  logic [6:0]  status_addr_q;
  logic [15:0] status_data_q, pwr_status_q;
  logic [31:0] vendor_id_q;

  always_ff @(posedge ac97_bitclk) begin
    if (!ac97_rst_b) begin
      codec_ready_q  <= 1'b0;
      status_valid_q <= 1'b0;
      status_addr_q  <= '0;
      status_data_q  <= '0;
      pwr_status_q   <= '0;
      vendor_id_q    <= '0;
    end else begin
      status_valid_q <= rsp_hit;
      if (s0_vld) codec_ready_q <= s0_q.tag[0];
      if (rsp_hit) begin
        status_addr_q <= s0_q.idx;
        status_data_q <= s0_q.rdata;
        case (s0_q.idx)
          7'h26:   pwr_status_q       <= s0_q.rdata;
          7'h7C:   vendor_id_q[31:16] <= s0_q.rdata;
          7'h7E:   vendor_id_q[15:0]  <= s0_q.rdata;
          default: ;
        endcase
      end
    end
  end

  // Capture FIFO: a pop frees the slot a same-cycle push needs when full.
  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level;
  logic          empty, full, pop, accept, drop, overflow_q;

  assign empty  = (level == '0);
  assign full   = (level == LW'(FIFO_DEPTH));
  assign pop    = !empty & bus.pcm_ready;
  assign accept = push & (!full | pop);
  assign drop   = push & full & !pop;

  always_ff @(posedge ac97_bitclk) begin
    if (!ac97_rst_b) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      if (accept && !pop)      level <= level + 1'b1;
      else if (pop && !accept) level <= level - 1'b1;
      if (drop) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge ac97_bitclk) begin
    if (ac97_rst_b && accept) mem[wr_ptr] <= push_data;
  end

`ifdef AC97_RX_DROP_COUNT_EN
  logic [7:0] drop_cnt;
  always_ff @(posedge ac97_bitclk) begin
    if (!ac97_rst_b)                   drop_cnt <= '0;
    else if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
  end
  assign bus.drop_count = drop_cnt;
`else
  assign bus.drop_count = '0;
`endif

  assign bus.codec_ready  = codec_ready_q;
  assign bus.status_valid = status_valid_q;
  assign bus.status_addr  = status_addr_q;
  assign bus.status_data  = status_data_q;
  assign bus.pwr_status   = pwr_status_q;
  assign bus.vendor_id    = vendor_id_q;
  assign bus.pcm_valid    = !empty;
  assign bus.pcm_data     = empty ? 32'h0 : mem[rd_ptr];
  assign bus.pcm_level    = level;
  assign bus.overflow     = overflow_q;
endmodule

// File: tb/tb_ac97_frame_rx.sv
// Directed bench for ac97_frame_rx: register responses, cache registers, capture FIFO fill/overflow/drain, reset.
module tb_ac97_frame_rx;
  localparam int DEPTH = 16;

  logic ac97_bitclk = 1'b0;
  logic ac97_rst_b  = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 ac97_bitclk = ~ac97_bitclk;

  ac97_frame_rx_if #(.FIFO_DEPTH(DEPTH)) bus ();
  ac97_frame_rx #(.FIFO_DEPTH(DEPTH)) dut (
    .ac97_bitclk (ac97_bitclk),
    .ac97_rst_b  (ac97_rst_b),
    .bus         (bus)
  );

`ifdef AC97_RX_DROP_COUNT_EN
  localparam logic [7:0] EXP_DROPS = 8'd3;
`else
  localparam logic [7:0] EXP_DROPS = 8'd0;
`endif

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // tagv[0] = codec ready, tagv[n] = slot n valid; slot bit 19 goes to the slot's first frame bit.
  function automatic logic [255:0] mk(input logic [4:0] tagv, input logic [6:0] idx,
                                      input logic [15:0] rdata, input logic [15:0] l,
                                      input logic [15:0] r);
    logic [255:0] f;
    logic [19:0]  s1, s2, s3, s4;
    f  = '0;
    s1 = {1'b0, idx, 12'h0};
    s2 = {rdata, 4'h0};
    s3 = {l, 4'h0};
    s4 = {r, 4'h0};
    for (int i = 0; i < 5; i++) f[i] = tagv[i];
    for (int b = 0; b < 20; b++) begin
      f[16+19-b] = s1[b];
      f[36+19-b] = s2[b];
      f[56+19-b] = s3[b];
      f[76+19-b] = s4[b];
    end
    return f;
  endfunction

  // Returns at E1 + 1, where E0 is the edge sampling the strobe.
  task automatic send(input logic [255:0] f);
    @(posedge ac97_bitclk); #1;
    bus.ac97_in_frame = f;
    bus.ac97_strobe   = 1'b1;
    @(posedge ac97_bitclk); #1;
    bus.ac97_strobe   = 1'b0;
    @(posedge ac97_bitclk); #1;
  endtask

  task automatic gap();
    repeat (253) @(posedge ac97_bitclk);
    #1;
  endtask

  task automatic pop1();
    bus.pcm_ready = 1'b1;
    @(posedge ac97_bitclk); #1;
    bus.pcm_ready = 1'b0;
  endtask

  initial begin
    logic [255:0] f;
    bus.ac97_strobe   = 1'b1;
    bus.ac97_in_frame = mk(5'b11111, 7'h26, 16'hDEAD, 16'h1111, 16'h2222);
    bus.pcm_ready     = 1'b0;
    repeat (3) @(posedge ac97_bitclk);
    #1;
    bus.ac97_strobe = 1'b0;
    ac97_rst_b      = 1'b1;
    repeat (3) @(posedge ac97_bitclk);
    #1;
    chk("rst_codec_ready", bus.codec_ready, 0);
    chk("rst_status_valid", bus.status_valid, 0);
    chk("rst_pcm_valid", bus.pcm_valid, 0);
    chk("rst_pcm_level", bus.pcm_level, 0);
    chk("rst_pcm_data", bus.pcm_data, 0);
    chk("rst_overflow", bus.overflow, 0);
    chk("rst_drop_count", bus.drop_count, 0);
    chk("rst_status_addr", bus.status_addr, 0);
    chk("rst_pwr_vendor", {bus.pwr_status, bus.vendor_id}, 0);

    // Not ready: everything ignored
    f = '1; f[0] = 1'b0;
    send(f);
    chk("nr_status_valid", bus.status_valid, 0);
    chk("nr_codec_ready", bus.codec_ready, 0);
    chk("nr_pcm_level", bus.pcm_level, 0);
    gap();

    // Tag 0xF000: ready, slot1, slot2, slot3 valid
    send(mk(5'b01111, 7'h26, 16'h000F, 16'h5555, 16'h7777));
    chk("pwr_status_valid", bus.status_valid, 1);
    chk("pwr_codec_ready", bus.codec_ready, 1);
    chk("pwr_status_addr", bus.status_addr, 7'h26);
    chk("pwr_status_data", bus.status_data, 16'h000F);
    chk("pwr_status", bus.pwr_status, 16'h000F);
    chk("pwr_pcm_level", bus.pcm_level, 1);
    chk("pwr_pcm_data", bus.pcm_data, 32'h5555_0000);
    @(posedge ac97_bitclk); #1;
    chk("pwr_valid_onecycle", bus.status_valid, 0);
    pop1();
    chk("pwr_pop_level", bus.pcm_level, 0);
    chk("pwr_pop_valid", bus.pcm_valid, 0);
    gap();

    send(mk(5'b00111, 7'h7C, 16'h4144, 16'h0, 16'h0));
    chk("vid_hi_valid", bus.status_valid, 1);
    chk("vid_hi", bus.vendor_id, 32'h4144_0000);
    chk("vid_hi_pwr_keep", bus.pwr_status, 16'h000F);
    gap();
    send(mk(5'b00111, 7'h7E, 16'h5374, 16'h0, 16'h0));
    chk("vid_full", bus.vendor_id, 32'h4144_5374);
    chk("vid_lo_addr", bus.status_addr, 7'h7E);
    gap();
    send(mk(5'b00111, 7'h02, 16'hBEEF, 16'h0, 16'h0));
    chk("other_addr", bus.status_addr, 7'h02);
    chk("other_data", bus.status_data, 16'hBEEF);
    chk("other_cache_keep", {bus.pwr_status, bus.vendor_id}, {16'h000F, 32'h4144_5374});
    chk("other_pcm_level", bus.pcm_level, 0);
    gap();
    send(mk(5'b00011, 7'h26, 16'h1234, 16'h0, 16'h0));
    chk("notag2_no_valid", bus.status_valid, 0);
    chk("notag2_addr_keep", bus.status_addr, 7'h02);
    chk("notag2_pwr_keep", bus.pwr_status, 16'h000F);
    gap();

    // Stereo capture, then left only
    send(mk(5'b11001, 7'h26, 16'hFFFF, 16'h1234, 16'hABCD));
    chk("pcm1_no_status", bus.status_valid, 0);
    chk("pcm1_level", bus.pcm_level, 1);
    chk("pcm1_data", bus.pcm_data, 32'h1234_ABCD);
    gap();
    send(mk(5'b01001, 7'h0, 16'h0, 16'h1234, 16'hABCD));
    chk("pcm2_level", bus.pcm_level, 2);
    chk("pcm2_head_hold", bus.pcm_data, 32'h1234_ABCD);
    pop1();
    chk("pcm2_data", bus.pcm_data, 32'h1234_0000);
    chk("pcm2_level_pop", bus.pcm_level, 1);
    pop1();
    chk("pcm_drained", bus.pcm_valid, 0);
    gap();

    // Fill past full with the consumer stalled
    for (int k = 0; k < DEPTH + 3; k++) begin
      send(mk(5'b11001, 7'h0, 16'h0, 16'(16'h1000 + k), 16'(16'h2000 + k)));
      if (k == DEPTH - 1) begin
        chk("full_level", bus.pcm_level, DEPTH);
        chk("full_no_overflow", bus.overflow, 0);
      end
      gap();
    end
    chk("ovf_level", bus.pcm_level, DEPTH);
    chk("ovf_flag", bus.overflow, 1);
    chk("ovf_drop_count", bus.drop_count, EXP_DROPS);
    chk("ovf_head", bus.pcm_data, 32'h1000_2000);

    // Push coincides with pop while full
    @(posedge ac97_bitclk); #1;
    bus.ac97_in_frame = mk(5'b11001, 7'h0, 16'h0, 16'hCAFE, 16'hF00D);
    bus.ac97_strobe   = 1'b1;
    @(posedge ac97_bitclk); #1;
    bus.ac97_strobe   = 1'b0;
    bus.pcm_ready     = 1'b1;
    @(posedge ac97_bitclk); #1;
    bus.pcm_ready     = 1'b0;
    chk("pp_level", bus.pcm_level, DEPTH);
    chk("pp_drop_count", bus.drop_count, EXP_DROPS);
    chk("pp_head", bus.pcm_data, 32'h1001_2001);
    for (int k = 1; k < DEPTH; k++) begin
      chk("drain_head", bus.pcm_data, {16'(16'h1000 + k), 16'(16'h2000 + k)});
      pop1();
    end
    chk("tail_level", bus.pcm_level, 1);
    chk("tail_data", bus.pcm_data, 32'hCAFE_F00D);
    pop1();
    chk("tail_empty", bus.pcm_level, 0);
    chk("ovf_sticky", bus.overflow, 1);
    gap();

    // Reset while a frame sits between stages
    @(posedge ac97_bitclk); #1;
    bus.ac97_in_frame = mk(5'b11111, 7'h26, 16'h5A5A, 16'h1111, 16'h2222);
    bus.ac97_strobe   = 1'b1;
    @(posedge ac97_bitclk); #1;
    bus.ac97_strobe   = 1'b0;
    ac97_rst_b        = 1'b0;
    @(posedge ac97_bitclk); #1;
    ac97_rst_b        = 1'b1;
    @(posedge ac97_bitclk); #1;
    chk("mid_rst_status_valid", bus.status_valid, 0);
    chk("mid_rst_level", bus.pcm_level, 0);
    chk("mid_rst_codec_ready", bus.codec_ready, 0);
    chk("mid_rst_overflow", bus.overflow, 0);
    chk("mid_rst_pwr", bus.pwr_status, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
